// File: rtl/sprite_fetch_arbiter.sv
// Fixed-priority arbiter sharing one sprite-memory read port among N requesters.
// Tracks read ownership through the memory latency and keeps per-frame statistics.
module sprite_fetch_arbiter #(
  parameter int unsigned N      = 4,
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned ID_W   = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic [N-1:0]        req_on,
  input  logic [N*ADDR_W-1:0] req_addr,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  input  logic [DATA_W-1:0]   mem_data,
  output logic [N-1:0]        grant,
  output logic                pix_valid,
  output logic [ID_W-1:0]     pix_owner,
  output logic [DATA_W-1:0]   pix_data,
  output logic [CNT_W-1:0]    conflict_count,
  output logic [CNT_W-1:0]    stall_count
);

  // arbitration results
  logic              any_req;
  logic              issue;
  logic              found;
  logic [ID_W-1:0]   winner;
  logic [ADDR_W-1:0] win_addr;
  logic [CNT_W-1:0]  req_cnt;

  // statistics
  logic [CNT_W-1:0]  conf_inc;
  logic [CNT_W-1:0]  stall_inc;
  logic [CNT_W:0]    conf_sum;
  logic [CNT_W:0]    stall_sum;

  // state
  logic [ADDR_W-1:0]            mem_addr_q,    mem_addr_d;
  logic                         mem_rd_q,      mem_rd_d;
  logic [N-1:0]                 grant_q,       grant_d;
  logic [ID_W-1:0]              owner_q,       owner_d;
  logic [RD_LAT-1:0]            tag_vld_q,     tag_vld_d;
  logic [RD_LAT-1:0][ID_W-1:0]  tag_own_q,     tag_own_d;
  logic                         pix_valid_q,   pix_valid_d;
  logic [ID_W-1:0]              pix_owner_q,   pix_owner_d;
  logic [DATA_W-1:0]            pix_data_q,    pix_data_d;
  logic [CNT_W-1:0]             conflict_q,    conflict_d;
  logic [CNT_W-1:0]             stall_q,       stall_d;

  // Lowest index wins; also counts requesters for the conflict statistics.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    win_addr = '0;
    req_cnt  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      req_cnt = req_cnt + CNT_W'(req_on[i]);
      if (req_on[i] && !found) begin
        found    = 1'b1;
        winner   = ID_W'(i);
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
    any_req = found;
    issue   = found & mem_ready;
  end

  // Issue stage; address holds when nothing is issued.
  always_comb begin
    mem_rd_d   = issue;
    grant_d    = issue ? (N'(1) << winner) : '0;
    mem_addr_d = issue ? win_addr : mem_addr_q;
    owner_d    = winner;
  end

  // Tag pipeline fed from the registered issue stage so its exit lines up with mem_data.
  always_comb begin
    tag_vld_d    = '0;
    tag_own_d    = '0;
    tag_vld_d[0] = mem_rd_q;
    tag_own_d[0] = owner_q;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  // Return stage: capture data for valid tags, otherwise hold the last pixel.
  always_comb begin
    pix_valid_d = tag_vld_q[RD_LAT-1];
    pix_owner_d = pix_owner_q;
    pix_data_d  = pix_data_q;
    if (tag_vld_q[RD_LAT-1]) begin
      pix_owner_d = tag_own_q[RD_LAT-1];
      pix_data_d  = mem_data;
    end
  end

  // Saturating per-frame counters; frame_start restarts with this cycle's increment.
  always_comb begin
    conf_inc  = '0;
    stall_inc = '0;
    if (issue) begin
      conf_inc = req_cnt - CNT_W'(1);
    end else if (any_req) begin
      conf_inc  = req_cnt;
      stall_inc = CNT_W'(1);
    end
    conf_sum  = {1'b0, conflict_q} + {1'b0, conf_inc};
    stall_sum = {1'b0, stall_q} + {1'b0, stall_inc};
    if (frame_start) begin
      conflict_d = conf_inc;
      stall_d    = stall_inc;
    end else begin
      conflict_d = conf_sum[CNT_W]  ? '1 : conf_sum[CNT_W-1:0];
      stall_d    = stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      grant_q     <= '0;
      owner_q     <= '0;
      tag_vld_q   <= '0;
      tag_own_q   <= '0;
      pix_valid_q <= 1'b0;
      pix_owner_q <= '0;
      pix_data_q  <= '0;
      conflict_q  <= '0;
      stall_q     <= '0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      tag_vld_q   <= tag_vld_d;
      tag_own_q   <= tag_own_d;
      pix_valid_q <= pix_valid_d;
      pix_owner_q <= pix_owner_d;
      pix_data_q  <= pix_data_d;
      conflict_q  <= conflict_d;
      stall_q     <= stall_d;
    end
  end

  assign mem_addr       = mem_addr_q;
  assign mem_rd         = mem_rd_q;
  assign grant          = grant_q;
  assign pix_valid      = pix_valid_q;
  assign pix_owner      = pix_owner_q;
  assign pix_data       = pix_data_q;
  assign conflict_count = conflict_q;
  assign stall_count    = stall_q;

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Testbench for sprite_fetch_arbiter: directed scenarios plus random traffic
// compared against a cycle-indexed behavioural model of grants, returns and statistics.
module tb_sprite_fetch_arbiter;
  localparam int N      = 4;
  localparam int ADDR_W = 21;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;
  localparam int ID_W   = 2;
  localparam int CNT_W  = 16;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int VW     = 1 + N + ADDR_W + 1 + ID_W + DATA_W + 2*CNT_W;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                frame_start;
  logic [N-1:0]        req_on;
  logic [N*ADDR_W-1:0] req_addr;
  logic                mem_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_rd;
  logic [DATA_W-1:0]   mem_data;
  logic [N-1:0]        grant;
  logic                pix_valid;
  logic [ID_W-1:0]     pix_owner;
  logic [DATA_W-1:0]   pix_data;
  logic [CNT_W-1:0]    conflict_count;
  logic [CNT_W-1:0]    stall_count;

  sprite_fetch_arbiter #(
    .N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .ID_W(ID_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .req_on(req_on),
    .req_addr(req_addr), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .grant(grant), .pix_valid(pix_valid), .pix_owner(pix_owner),
    .pix_data(pix_data), .conflict_count(conflict_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: expectations for the current cycle plus a schedule of returns by cycle number.
  logic              exp_rd;
  logic [N-1:0]      exp_grant;
  logic [ADDR_W-1:0] exp_addr;
  logic              exp_pv;
  logic [ID_W-1:0]   m_own;
  logic [DATA_W-1:0] m_data;
  int                exp_conf, exp_stall;
  bit                sch_pv   [16];
  int                sch_own  [16];
  logic [DATA_W-1:0] sch_data [16];

  wire [VW-1:0] obs_vec = {mem_rd, grant, mem_addr, pix_valid, pix_owner, pix_data,
                           conflict_count, stall_count};

  function automatic logic [VW-1:0] exp_vec();
    return {exp_rd, exp_grant, exp_addr, exp_pv, m_own, m_data,
            CNT_W'(exp_conf), CNT_W'(exp_stall)};
  endfunction

  function automatic void model_reset();
    exp_rd = 1'b0; exp_grant = '0; exp_addr = '0; exp_pv = 1'b0;
    m_own = '0; m_data = '0; exp_conf = 0; exp_stall = 0;
    for (int i = 0; i < 16; i++) begin
      sch_pv[i] = 1'b0; sch_own[i] = 0; sch_data[i] = '0;
    end
  endfunction

  // Apply current inputs for one cycle and advance the model by the same cycle.
  task automatic tick();
    int  pop = $countones(req_on);
    bit  any = (pop > 0);
    bit  iss = any && mem_ready;
    int  w   = 0;
    int  ci  = iss ? pop - 1 : (any ? pop : 0);
    int  si  = (any && !mem_ready) ? 1 : 0;
    int  nc, ns;
    for (int i = N - 1; i >= 0; i--) if (req_on[i]) w = i;
    nc = frame_start ? ci : ((exp_conf + ci > CMAX) ? CMAX : exp_conf + ci);
    ns = frame_start ? si : ((exp_stall + si > CMAX) ? CMAX : exp_stall + si);
    if (iss) begin
      sch_pv[(cyc + 2 + RD_LAT) % 16]  = 1'b1;
      sch_own[(cyc + 2 + RD_LAT) % 16] = w;
    end
    sch_data[(cyc + 1) % 16] = mem_data;
    @(posedge clk);
    #1;
    cyc++;
    exp_rd    = iss;
    exp_grant = iss ? N'(1 << w) : '0;
    if (iss) exp_addr = req_addr[w*ADDR_W +: ADDR_W];
    exp_conf  = nc;
    exp_stall = ns;
    exp_pv    = sch_pv[cyc % 16];
    if (exp_pv) begin
      m_own  = ID_W'(sch_own[cyc % 16]);
      m_data = sch_data[cyc % 16];
    end
    sch_pv[cyc % 16] = 1'b0;
  endtask

  task automatic rand_addr();
    for (int i = 0; i < N; i++) req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_start = 1'b0; req_on = '0; req_addr = '0;
    mem_ready = 1'b1; mem_data = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs_vec !== '0) begin
      n_fail++; $display("FAIL reset_state got=%h want=0", obs_vec);
    end
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 10; k++) begin
      mem_data = DATA_W'($urandom);
      tick();
      n_checks++;
      if (mem_rd !== 1'b0 || grant !== '0 || pix_valid !== 1'b0 ||
          conflict_count !== '0 || stall_count !== '0) begin
        n_fail++;
        $display("FAIL idle cyc=%0d got rd=%b grant=%b pv=%b conf=%0d stall=%0d want all 0",
                 cyc, mem_rd, grant, pix_valid, conflict_count, stall_count);
      end
    end
  endtask

  task automatic test_single();
    int c0 = cyc;
    rand_addr();
    req_addr[2*ADDR_W +: ADDR_W] = 21'h00123;
    req_on = 4'b0100; mem_ready = 1'b1;
    tick();
    n_checks++;
    if (mem_rd !== 1'b1 || grant !== 4'b0100 || mem_addr !== 21'h00123) begin
      n_fail++;
      $display("FAIL single_issue got rd=%b grant=%b addr=%h want 1/0100/00123",
               mem_rd, grant, mem_addr);
    end
    req_on = '0;
    for (int k = 0; k < 5; k++) begin
      mem_data = (cyc == c0 + 3) ? 8'h5A : DATA_W'($urandom);
      tick();
      n_checks++;
      if (pix_valid !== (cyc == c0 + 4) ||
          (cyc == c0 + 4 && (pix_owner !== 2'd2 || pix_data !== 8'h5A))) begin
        n_fail++;
        $display("FAIL single_return cyc=%0d got pv=%b own=%0d data=%h want pv=%0b own=2 data=5A",
                 cyc - c0, pix_valid, pix_owner, pix_data, (cyc == c0 + 4));
      end
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL single_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    int pv_cnt = 0;
    req_on = 4'b1011; mem_ready = 1'b1; frame_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_addr(); mem_data = DATA_W'($urandom);
      tick();
      frame_start = 1'b0;
      n_checks++;
      if (grant !== 4'b0001 || mem_rd !== 1'b1) begin
        n_fail++; $display("FAIL b2b_grant k=%0d got=%b want=0001", k, grant);
      end
    end
    n_checks++;
    if (conflict_count !== 16'd6) begin
      n_fail++; $display("FAIL b2b_conflict got=%0d want=6", conflict_count);
    end
    req_on = '0;
    for (int k = 0; k < 6; k++) begin
      mem_data = DATA_W'($urandom);
      tick();
      if (pix_valid === 1'b1 && pix_owner === 2'd0) pv_cnt++;
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL b2b_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec());
      end
    end
    n_checks++;
    if (pv_cnt != 3) begin
      n_fail++; $display("FAIL b2b_pixels got=%0d want=3", pv_cnt);
    end
  endtask

  task automatic test_stall();
    req_on = 4'b0011; mem_ready = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    n_checks++;
    if (mem_rd !== 1'b0 || stall_count !== 16'd2 || conflict_count !== 16'd4) begin
      n_fail++;
      $display("FAIL stall_count got rd=%b stall=%0d conf=%0d want 0/2/4",
               mem_rd, stall_count, conflict_count);
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_checks++;
    if (stall_count !== 16'd1 || conflict_count !== 16'd2) begin
      n_fail++;
      $display("FAIL stall_frame got stall=%0d conf=%0d want 1/2", stall_count, conflict_count);
    end
    req_on = '0; mem_ready = 1'b1;
  endtask

  task automatic test_saturation();
    req_on = 4'b1111; mem_ready = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (16382) tick();
    req_on = 4'b0011;
    tick();
    n_checks++;
    if (conflict_count !== 16'hFFFE) begin
      n_fail++; $display("FAIL sat_pre got=%h want=FFFE", conflict_count);
    end
    req_on = 4'b0111; mem_ready = 1'b1;
    tick();
    n_checks++;
    if (conflict_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_hit got=%h want=FFFF", conflict_count);
    end
    req_on = 4'b1111;
    repeat (3) tick();
    n_checks++;
    if (conflict_count !== 16'hFFFF || obs_vec !== exp_vec()) begin
      n_fail++; $display("FAIL sat_hold got=%h want=FFFF (vec %h vs %h)",
                         conflict_count, obs_vec, exp_vec());
    end
    req_on = '0;
  endtask

  task automatic test_reset_inflight();
    bit seen = 1'b0;
    req_on = 4'b0010; mem_ready = 1'b1; rand_addr();
    tick();
    tick();
    req_on = '0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs_vec !== '0) begin
      n_fail++; $display("FAIL reset_async got=%h want=0", obs_vec);
    end
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      mem_data = DATA_W'($urandom);
      tick();
      if (pix_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL reset_drop got pix_valid=1 after release want 0");
    end
    n_checks++;
    if (obs_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_model got=%h want=%h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      req_on      = N'($urandom);
      mem_ready   = ($urandom_range(3) != 0);
      frame_start = ($urandom_range(15) == 0);
      mem_data    = DATA_W'($urandom);
      rand_addr();
      tick();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec());
      end
    end
    req_on = '0; frame_start = 1'b0;
    repeat (RD_LAT + 2) begin
      tick();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random_drain cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_saturation();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_fetch_arbiter.md
Name: sprite_fetch_arbiter

Overview:
- Shares one sprite-memory read port among N per-pixel sprite/animation blocks (player, enemies, bullets), each presenting an "on" flag and a sprite address every pixel cycle.
- Grants each cycle by fixed priority (index 0 = topmost layer), issues the read and tracks ownership through the memory read latency.
- Returns the fetched pixel tagged with its owner.
- Keeps per-frame conflict and stall statistics for debug.
- Sits between the sprite animation blocks and the sprite SRAM/ROM, ahead of the colour mapper.

Parameters:
N, 4, number of requesters (2..8)
ADDR_W, 21, sprite address width
DATA_W, 8, encoded pixel width
RD_LAT, 2, memory read latency in cycles (1..4)
ID_W, 2, owner tag width; must equal ceil(log2(N))
CNT_W, 16, statistics counter width

Ports:
Clk  in  1  pixel clock; all state on rising edge
Reset  in  1  asynchronous, active-low; clears all state
frame_start  in  1  one-cycle pulse at first pixel of a frame
req_on  in  N  requester i wants a fetch this cycle
req_addr  in  N*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W]
mem_ready  in  1  memory accepts a read this cycle; low = port busy
mem_addr  out  ADDR_W  registered read address
mem_rd  out  1  registered read strobe
mem_data  in  DATA_W  read data, valid exactly RD_LAT cycles after mem_rd high
grant  out  N  registered one-hot grant aligned with mem_rd
pix_valid  out  1  pix_data/pix_owner valid
pix_owner  out  ID_W  index of the requester owning pix_data
pix_data  out  DATA_W  fetched pixel
conflict_count  out  CNT_W  losing requests this frame, saturating
stall_count  out  CNT_W  cycles this frame with any req_on while mem_ready low, saturating

Behaviour:
- Reset low, asynchronous: mem_addr=0, mem_rd=0, grant=0, pix_valid=0, pix_owner=0, pix_data=0, both counters=0, tag pipeline cleared. Reset asserted mid-operation drops all in-flight reads; no pix_valid appears for them after release.
- Arbitration, combinational on cycle t inputs: winner = lowest i with req_on[i]=1. Issue only if mem_ready=1 and any req_on.
- Issue stage, edge ending t: mem_rd<=issue; grant<=issue ? onehot(winner) : 0; mem_addr<=issue ? req_addr[winner] : hold previous value.
- Tag pipeline: RD_LAT-deep shift of {valid, owner}. Entry loaded from the issue stage; advances every cycle, never stalls.
- Return stage: when the tag exiting the pipeline is valid, register pix_data<=mem_data, pix_owner<=tag owner, pix_valid<=1. Otherwise pix_valid<=0 and pix_data/pix_owner hold.
- Latency: req at cycle 0 -> mem_rd cycle 1 -> mem_data cycle 1+RD_LAT -> pix_valid cycle 2+RD_LAT. Throughput is one pixel per cycle; back-to-back grants allowed.
- No request queuing. A losing or stalled request is dropped; requesters re-present each pixel.
- conflict_count per cycle increment = (popcount(req_on) - 1) if issue, popcount(req_on) if any req_on and mem_ready=0, else 0. Saturates at all-ones.
- stall_count increments by 1 when any req_on and mem_ready=0. Saturates.
- frame_start at edge: each counter <= this cycle's increment, so the new frame includes the current cycle. The fetch pipeline is unaffected.
- Width rules: increments are computed in CNT_W bits. Saturation check uses CNT_W+1-bit sum.
- req_addr of non-winners is ignored. req_addr of the winner is captured unmodified.

Test Plan:
- Reset release, no requests for 10 cycles -> mem_rd=0, grant=0, pix_valid=0, counters 0.
- req_on=4'b0100, addr2=21'h00123, mem_ready=1, RD_LAT=2, mem_data=8'h5A returned cycle 3 -> mem_rd/grant=4'b0100/mem_addr=21'h00123 in cycle 1; pix_valid=1, pix_owner=2, pix_data=8'h5A in cycle 4 only.
- req_on=4'b1011 for 3 consecutive cycles -> grant 4'b0001 each cycle; 3 back-to-back pix_valid with owner 0; conflict_count=6.
- mem_ready=0 for 2 cycles with req_on=4'b0011 -> no mem_rd; stall_count=2, conflict_count=4. frame_start on a third stalled cycle -> stall_count=1, conflict_count=2.
- Force counter to 16'hFFFE, apply 2-loser conflict -> conflict_count=16'hFFFF; further conflicts hold it.
- Reset pulsed low with 2 reads in flight -> outputs zero immediately; no pix_valid after release until a new request.
